// File: rtl/nodf_pkg.sv
// nodf_pkg: shared types and default widths for the non-dataflow
// handshake tracker.
//   phase_e    - tracker phase encoding (IDLE/RUN/HOLD/FINISHED)
//   NODF_CNT_W - default width of event and cycle counters
//   NODF_LAT_W - default width of latency registers and the timer
package nodf_pkg;

    localparam int NODF_CNT_W = 32;
    localparam int NODF_LAT_W = 32;

    typedef enum logic [1:0] {
        PH_IDLE     = 2'd0,
        PH_RUN      = 2'd1,
        PH_HOLD     = 2'd2,
        PH_FINISHED = 2'd3
    } phase_e;

endpackage

// File: rtl/nodf_sat_counter.sv
// nodf_sat_counter: saturating up-counter shared by every statistic.
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-low reset, clears the count
//   i_clear  - synchronous clear to 0
//   i_inc    - increment by one, holding at all-ones
//   i_freeze - hold the count, overrides clear and increment
//   o_count  - current count
module nodf_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic             i_freeze,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {WIDTH{1'b1}});
    assign o_count  = r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (!i_freeze) begin
            if (i_clear)
                r_count <= '0;
            else if (i_inc && !w_at_max)
                r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/nodf_handshake_tracker.sv
// nodf_handshake_tracker: status tracker for the block-level handshake
// (ap_start/ap_ready/ap_done/ap_continue) of one non-dataflow HLS module.
// Sub-call instances tie ap_start/ap_done/ap_continue low and only
// ap_ready and the cycle counter move.
//
// Optional feature: define NODF_STALL_CNT_EN to add stall_count, the
// number of cycles spent in HOLD.
//
// Ports:
//   clock, reset   - rising-edge clock, async active-low reset
//   ap_start/ap_ready/ap_done/ap_continue - observed handshake
//   finish         - end-of-run request, freezes all statistics
//   phase          - 0 IDLE, 1 RUN, 2 HOLD, 3 FINISHED
//   start_count, ready_count, done_count, cycle_count - saturating counters
//   last_latency, max_latency - edges from start cycle to done cycle
//   err_done_idle, err_start_drop - sticky protocol errors
//   finished       - high once finish has been sampled
//   stall_count    - HOLD cycles (NODF_STALL_CNT_EN only)
module nodf_handshake_tracker
    import nodf_pkg::*;
#(
    parameter int CNT_W = NODF_CNT_W,
    parameter int LAT_W = NODF_LAT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] start_count,
    output logic [CNT_W-1:0] ready_count,
    output logic [CNT_W-1:0] done_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [LAT_W-1:0] last_latency,
    output logic [LAT_W-1:0] max_latency,
    output logic             err_done_idle,
    output logic             err_start_drop,
`ifdef NODF_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_count,
`endif
    output logic             finished
);

    phase_e           r_state;
    phase_e           w_state_nxt;
    logic             r_ready_seen;
    logic             r_err_done_idle;
    logic             r_err_start_drop;
    logic [LAT_W-1:0] r_last_latency;
    logic [LAT_W-1:0] r_max_latency;

    logic             w_frz;
    logic             w_idle;
    logic             w_run;
    logic             w_start_acc;
    logic             w_done_acc;
    logic [LAT_W-1:0] w_timer;
    logic [LAT_W-1:0] w_timer_inc;
    logic [LAT_W-1:0] w_lat;

    // finish wins over everything else sampled in the same cycle
    assign w_frz  = finish || (r_state == PH_FINISHED);
    assign w_idle = (r_state == PH_IDLE);
    assign w_run  = (r_state == PH_RUN);

    // A start is accepted from IDLE, or as a back-to-back restart when a
    // RUN completes and is released in the same cycle.
    assign w_start_acc = !w_frz && ((w_idle && ap_start) ||
                                    (w_run && ap_done && ap_continue && ap_start));
    assign w_done_acc  = !w_frz && ((w_run && ap_done) ||
                                    (w_idle && ap_start && ap_done));

    // The timer holds the edges already elapsed since the start edge, so
    // the done edge itself is one more; saturation holds at all-ones.
    assign w_timer_inc = (w_timer == {LAT_W{1'b1}}) ? w_timer : w_timer + LAT_W'(1);
    assign w_lat       = w_idle ? '0 : w_timer_inc;

    // ---------------- phase FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= PH_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (finish) begin
            w_state_nxt = PH_FINISHED;
        end else begin
            case (r_state)
                PH_IDLE: begin
                    // start+done together completes the transaction at once
                    if (ap_start && ap_done)
                        w_state_nxt = ap_continue ? PH_IDLE : PH_HOLD;
                    else if (ap_start)
                        w_state_nxt = PH_RUN;
                end
                PH_RUN: begin
                    if (ap_done) begin
                        if (!ap_continue)
                            w_state_nxt = PH_HOLD;
                        else
                            w_state_nxt = ap_start ? PH_RUN : PH_IDLE;
                    end
                end
                PH_HOLD: begin
                    if (ap_continue)
                        w_state_nxt = PH_IDLE;
                end
                default: w_state_nxt = PH_FINISHED;
            endcase
        end
    end

    always_comb begin
        phase    = r_state;
        finished = (r_state == PH_FINISHED);
    end

    // ---------------- flags and latency ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready_seen     <= 1'b0;
            r_err_done_idle  <= 1'b0;
            r_err_start_drop <= 1'b0;
            r_last_latency   <= '0;
            r_max_latency    <= '0;
        end else if (!w_frz) begin
            if (w_start_acc)
                r_ready_seen <= 1'b0;
            else if (w_run && ap_ready)
                r_ready_seen <= 1'b1;

            if (w_idle && ap_done && !ap_start)
                r_err_done_idle <= 1'b1;
            if (w_run && !ap_start && !r_ready_seen)
                r_err_start_drop <= 1'b1;

            if (w_done_acc) begin
                r_last_latency <= w_lat;
                if (w_lat > r_max_latency)
                    r_max_latency <= w_lat;
            end
        end
    end

    assign err_done_idle  = r_err_done_idle;
    assign err_start_drop = r_err_start_drop;
    assign last_latency   = r_last_latency;
    assign max_latency    = r_max_latency;

    // ---------------- counters ----------------
    nodf_sat_counter #(.WIDTH(CNT_W)) u_start_cnt (
        .clock(clock), .reset(reset), .i_clear(1'b0), .i_inc(w_start_acc),
        .i_freeze(w_frz), .o_count(start_count)
    );

    nodf_sat_counter #(.WIDTH(CNT_W)) u_ready_cnt (
        .clock(clock), .reset(reset), .i_clear(1'b0), .i_inc(ap_ready),
        .i_freeze(w_frz), .o_count(ready_count)
    );

    nodf_sat_counter #(.WIDTH(CNT_W)) u_done_cnt (
        .clock(clock), .reset(reset), .i_clear(1'b0), .i_inc(w_done_acc),
        .i_freeze(w_frz), .o_count(done_count)
    );

    nodf_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clock(clock), .reset(reset), .i_clear(1'b0), .i_inc(1'b1),
        .i_freeze(w_frz), .o_count(cycle_count)
    );

    // latency timer: cleared on every accepted start, counts RUN cycles
    nodf_sat_counter #(.WIDTH(LAT_W)) u_timer (
        .clock(clock), .reset(reset), .i_clear(w_start_acc), .i_inc(w_run),
        .i_freeze(w_frz), .o_count(w_timer)
    );

`ifdef NODF_STALL_CNT_EN
    nodf_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clock(clock), .reset(reset), .i_clear(1'b0),
        .i_inc(r_state == PH_HOLD), .i_freeze(w_frz), .o_count(stall_count)
    );
`endif

endmodule

// File: tb/tb_nodf_handshake_tracker.sv
// Bench for nodf_handshake_tracker: directed cycles, a cycle-stamp
// reference model compared every cycle, and literal pins per scenario.
module tb_nodf_handshake_tracker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0;
    logic        ap_continue = 1'b0, finish = 1'b0;
    logic [1:0]  phase;
    logic [31:0] start_count, ready_count, done_count, cycle_count;
    logic [31:0] last_latency, max_latency;
    logic        err_done_idle, err_start_drop, finished;
`ifdef NODF_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    nodf_handshake_tracker #(.CNT_W(32), .LAT_W(32)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish),
        .phase(phase), .start_count(start_count), .ready_count(ready_count),
        .done_count(done_count), .cycle_count(cycle_count),
        .last_latency(last_latency), .max_latency(max_latency),
        .err_done_idle(err_done_idle), .err_start_drop(err_start_drop),
`ifdef NODF_STALL_CNT_EN
        .stall_count(stall_count),
`endif
        .finished(finished)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Latency is the difference of edge stamps between the accepting
    // start edge and the completing done edge.
    int     m_phase;
    longint m_start, m_ready, m_done, m_cyc, m_last, m_max, m_stall;
    bit     m_edi, m_esd, m_rdy_seen;
    longint m_edge, m_t0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_start = 0; m_ready = 0; m_done = 0; m_cyc = 0;
            m_last = 0; m_max = 0; m_stall = 0; m_edi = 0; m_esd = 0;
            m_rdy_seen = 0; m_edge = 0; m_t0 = 0;
        end else begin
            if (finish) begin
                m_phase = 3;
            end else if (m_phase != 3) begin
                int     ph;
                longint lat;
                ph = m_phase;
                m_cyc++;
                if (ap_ready) m_ready++;
                if (ph == 2) m_stall++;
                if (ph == 0) begin
                    if (ap_start) begin
                        m_start++; m_t0 = m_edge; m_rdy_seen = 0;
                        if (ap_done) begin
                            m_done++; m_last = 0;
                            m_phase = ap_continue ? 0 : 2;
                        end else begin
                            m_phase = 1;
                        end
                    end else if (ap_done) begin
                        m_edi = 1;
                    end
                end else if (ph == 1) begin
                    if (!ap_start && !m_rdy_seen) m_esd = 1;
                    if (ap_ready) m_rdy_seen = 1;
                    if (ap_done) begin
                        lat = m_edge - m_t0;
                        m_done++; m_last = lat;
                        if (lat > m_max) m_max = lat;
                        if (!ap_continue) m_phase = 2;
                        else if (ap_start) begin
                            m_start++; m_t0 = m_edge; m_rdy_seen = 0; m_phase = 1;
                        end else m_phase = 0;
                    end
                end else if (ph == 2) begin
                    if (ap_continue) m_phase = 0;
                end
            end
            m_edge++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clock) begin
        #1;
        chk("phase", phase, m_phase);
        chk("start_count", start_count, m_start);
        chk("ready_count", ready_count, m_ready);
        chk("done_count", done_count, m_done);
        chk("cycle_count", cycle_count, m_cyc);
        chk("last_latency", last_latency, m_last);
        chk("max_latency", max_latency, m_max);
        chk("err_done_idle", err_done_idle, m_edi);
        chk("err_start_drop", err_start_drop, m_esd);
        chk("finished", finished, m_phase == 3);
`ifdef NODF_STALL_CNT_EN
        chk("stall_count", stall_count, m_stall);
`endif
    end

    // one cycle of stimulus; returns 2 time units after the edge
    task automatic cy(input bit s, input bit r, input bit d, input bit c, input bit f);
        ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cy(0, 0, 0, 0, 0);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock); #2;
        do_reset();
        chk("rst_phase", phase, 0);
        chk("rst_start", start_count, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_finished", finished, 0);

        // basic transaction: start at 2, ready at 3, done+continue at 7
        cy(0,0,0,0,0); cy(0,0,0,0,0); cy(1,0,0,0,0); cy(0,1,0,0,0);
        cy(0,0,0,0,0); cy(0,0,0,0,0); cy(0,0,0,0,0); cy(0,0,1,1,0);
        chk("t1_start", start_count, 1);
        chk("t1_done", done_count, 1);
        chk("t1_last", last_latency, 5);
        chk("t1_max", max_latency, 5);
        chk("t1_phase", phase, 0);

        // HOLD: done at 4 without continue, done in HOLD ignored, continue at 9
        do_reset();
        cy(0,0,0,0,0); cy(1,0,0,0,0); cy(1,1,0,0,0); cy(0,0,0,0,0);
        cy(0,0,1,0,0);
        chk("t2_phase_hold", phase, 2);
        cy(0,0,0,0,0); cy(0,0,1,0,0); cy(0,0,0,0,0); cy(0,0,0,0,0);
        cy(0,0,0,1,0);
        chk("t2_phase_idle", phase, 0);
        chk("t2_done", done_count, 1);
        chk("t2_last", last_latency, 3);
        chk("t2_esd", err_start_drop, 0);
`ifdef NODF_STALL_CNT_EN
        chk("t2_stall", stall_count, 5);
`endif

        // start+done together in IDLE, then done alone in IDLE
        do_reset();
        cy(0,0,0,0,0); cy(1,0,1,1,0);
        chk("t3_start", start_count, 1);
        chk("t3_done", done_count, 1);
        chk("t3_last", last_latency, 0);
        chk("t3_phase", phase, 0);
        cy(0,0,1,0,0);
        chk("t3_edi", err_done_idle, 1);
        chk("t3_done2", done_count, 1);
        cy(1,0,1,0,0);
        chk("t3_hold", phase, 2);
        cy(0,0,0,1,0);
        chk("t3_idle", phase, 0);

        // back-to-back restart, then start dropped before ready
        do_reset();
        cy(1,0,0,0,0); cy(1,1,0,0,0); cy(0,0,0,0,0); cy(1,0,1,1,0);
        cy(1,1,0,0,0); cy(0,0,1,1,0);
        chk("t4_start", start_count, 2);
        chk("t4_done", done_count, 2);
        chk("t4_last", last_latency, 2);
        chk("t4_max", max_latency, 3);
        chk("t4_esd0", err_start_drop, 0);
        cy(1,0,0,0,0); cy(0,0,0,0,0);
        chk("t4_esd1", err_start_drop, 1);

        // tie-off usage, then finish freezes everything
        do_reset();
        cy(0,1,0,0,0); cy(0,0,0,0,0); cy(0,1,0,0,0); cy(0,0,0,0,0);
        cy(0,1,0,0,0); cy(0,1,0,0,0);
        chk("t5_ready", ready_count, 4);
        chk("t5_phase", phase, 0);
        chk("t5_cycle", cycle_count, 6);
        cy(1,1,0,0,1);
        chk("t5_finished", finished, 1);
        chk("t5_phase_fin", phase, 3);
        chk("t5_ready_fin", ready_count, 4);
        chk("t5_start_fin", start_count, 0);
        cy(0,1,0,0,0); cy(1,1,1,1,0); cy(0,1,0,0,0);
        chk("t5_ready_frz", ready_count, 4);
        chk("t5_cycle_frz", cycle_count, 6);
        chk("t5_still_fin", finished, 1);

        // asynchronous reset in the middle of RUN
        do_reset();
        cy(1,0,0,0,0); cy(1,1,0,0,0); cy(0,0,0,0,0);
        chk("t6_run", phase, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_phase", phase, 0);
        chk("t6_start", start_count, 0);
        chk("t6_ready", ready_count, 0);
        chk("t6_cycle", cycle_count, 0);
        chk("t6_esd", err_start_drop, 0);
        cy(0,0,0,0,0);
        reset = 1'b1;
        cy(0,0,0,0,0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nodf_handshake_tracker.md
Name: nodf_handshake_tracker

Overview:
- Synthesizable status tracker for one non-dataflow HLS module's block-level handshake (ap_start/ap_ready/ap_done/ap_continue).
- Instantiated once per monitored module (top or sub-call) beside the simulation status dumpers.
- Exposes transaction counts, latency statistics, current phase and sticky protocol-error flags.
- Sub-call instances tie ap_start, ap_done and ap_continue to 0 and observe only ap_ready.

Parameters:
- CNT_W, 32, width of every event and cycle counter.
- LAT_W, 32, width of the latency registers.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  1  start request of the monitored module.
- ap_ready  in  1  monitored module accepts inputs.
- ap_done  in  1  monitored module completes.
- ap_continue  in  1  downstream releases a completed result.
- finish  in  1  end-of-run request; freezes all statistics.
- phase  out  2  0 IDLE, 1 RUN, 2 HOLD, 3 FINISHED.
- start_count  out  CNT_W  accepted starts.
- ready_count  out  CNT_W  cycles with ap_ready=1.
- done_count  out  CNT_W  completions.
- cycle_count  out  CNT_W  cycles since reset release, up to finish.
- last_latency  out  LAT_W  latency of the most recent transaction.
- max_latency  out  LAT_W  largest latency seen.
- err_done_idle  out  1  sticky: ap_done=1 while IDLE without ap_start.
- err_start_drop  out  1  sticky: ap_start fell in RUN before ap_ready.
- finished  out  1  high from the cycle after finish is sampled.

Behaviour:
- reset=0 asynchronously clears every output, forces phase IDLE and clears internal timer and flags. This applies mid-transaction too.
- All updates occur on rising clock edges. Outputs are registered, one cycle after the sampled inputs.
- IDLE → RUN when ap_start=1. start_count +1 and timer cleared to 0.
- RUN: timer +1 per cycle. The first ap_ready=1 sets an internal ready_seen flag; ready_seen clears on entering RUN.
- ap_start=0 in RUN with ready_seen=0 sets err_start_drop.
- RUN with ap_done=1:
  - done_count +1.
  - last_latency = current timer value, i.e. the number of edges from the start cycle to the done cycle.
  - max_latency updated if larger.
  - Next phase: if ap_continue=1, IDLE, or RUN again (new start counted, timer 0) when ap_start=1 in the same cycle. If ap_continue=0, HOLD.
- IDLE with ap_start=1 and ap_done=1 in the same cycle: start and done are both counted, latency 0, and the phase follows the same ap_continue rule.
- HOLD → IDLE when ap_continue=1. Any ap_done in HOLD is ignored.
- ap_done=1 in IDLE with ap_start=0 sets err_done_idle; counters unchanged.
- ready_count increments on every ap_ready=1 cycle in any phase except FINISHED.
- All counters saturate at all-ones and never wrap. A latency timer that saturates holds at max.
- finish=1 sampled in any phase moves to FINISHED, sets finished and freezes all counters and flags. Only reset leaves FINISHED.
- finish has priority over every simultaneous event in the same cycle; that cycle's events are not counted.
- Tied-off sub-call usage (start, done and continue all 0) stays IDLE; only ready_count and cycle_count move.

Optional Feature:
- Macro NODF_STALL_CNT_EN.
- Defined: adds output stall_count (CNT_W), counting cycles spent in HOLD. It saturates, freezes on finish and clears on reset.
- Undefined: no port and no logic.

Decomposition:
- Shared package nodf_pkg holds the phase enum type (IDLE/RUN/HOLD/FINISHED) and the default width constants.
- One sub-module, nodf_sat_counter (parameterized width, inc, clear, freeze), is reused for every counter and the latency timer.

Test Plan:
- Reset, then start pulse at cycle 2, ap_ready at 3, ap_done at 7 with ap_continue=1 → start_count=1, done_count=1, last_latency=5, max_latency=5, phase IDLE.
- ap_done at cycle 4 with ap_continue=0, ap_continue raised at cycle 9 → phase HOLD over cycles 5–9, IDLE at 10; stall_count=5 with the macro defined.
- ap_start and ap_done together in IDLE with ap_continue=1 → start_count=1, done_count=1, last_latency=0; ap_done alone in IDLE → err_done_idle=1.
- ap_start dropped in RUN before any ap_ready → err_start_drop=1.
- Tie-off mode with 4 ap_ready pulses → ready_count=4, phase stays IDLE; finish=1 → finished=1 and counters freeze under further pulses.
- Reset asserted mid-RUN → all outputs 0 immediately, without waiting for a clock edge.
